// File: rtl/apb_lsram_arbiter.sv
// Two-requester APB3 sequencer: arbitrates M0/M1 req/done transfers onto one SRAM slave,
// running one SETUP/ACCESS transfer per grant with a bounded wait-state timeout.
module apb_lsram_arbiter #(
  parameter int unsigned APB_DWIDTH = 32,
  parameter int unsigned ARB_MODE   = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  M0_REQ,
  input  logic                  M0_WRITE,
  input  logic [19:0]           M0_ADDR,
  input  logic [APB_DWIDTH-1:0] M0_WDATA,
  output logic [APB_DWIDTH-1:0] M0_RDATA,
  output logic                  M0_DONE,
  output logic                  M0_ERR,
  input  logic                  M1_REQ,
  input  logic                  M1_WRITE,
  input  logic [19:0]           M1_ADDR,
  input  logic [APB_DWIDTH-1:0] M1_WDATA,
  output logic [APB_DWIDTH-1:0] M1_RDATA,
  output logic                  M1_DONE,
  output logic                  M1_ERR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [19:0]           PADDR,
  output logic [APB_DWIDTH-1:0] PWDATA,
  input  logic [APB_DWIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e                state_q, state_d;
  logic                  win_q, win_d;    // 0 = M0, 1 = M1
  logic                  last_q, last_d;  // master granted most recently
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [19:0]           paddr_q, paddr_d;
  logic [APB_DWIDTH-1:0] pwdata_q, pwdata_d;
  logic [APB_DWIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [APB_DWIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  m0_done_q, m0_done_d;
  logic                  m1_done_q, m1_done_d;
  logic                  m0_err_q, m0_err_d;
  logic                  m1_err_q, m1_err_d;
  logic [7:0]            cnt_q, cnt_d, cnt_inc;

  logic                  grant_m1;
  logic                  xfer_end;
  logic                  end_err;
  logic [APB_DWIDTH-1:0] end_rdata;

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    if (M0_REQ && M1_REQ) grant_m1 = (ARB_MODE == 0) ? 1'b0 : ~last_q;
    else                  grant_m1 = M1_REQ;
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_done_d  = 1'b0;
    m1_done_d  = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    cnt_d      = cnt_q;
    xfer_end   = 1'b0;
    end_err    = 1'b0;
    end_rdata  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (M0_REQ || M1_REQ) begin
          win_d    = grant_m1;
          pwrite_d = grant_m1 ? M1_WRITE : M0_WRITE;
          paddr_d  = grant_m1 ? M1_ADDR  : M0_ADDR;
          pwdata_d = grant_m1 ? M1_WDATA : M0_WDATA;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          xfer_end  = 1'b1;
          end_err   = PSLVERR;
          end_rdata = PRDATA;
        end else begin
          cnt_d = cnt_inc;
          // A zero TIMEOUT disables the abort; PREADY in the same cycle always wins.
          if (TIMEOUT != 0 && cnt_inc == TIMEOUT_CNT) begin
            xfer_end = 1'b1;
            end_err  = 1'b1;
          end
        end
        if (xfer_end) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = win_q;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (xfer_end) begin
      if (win_q) begin
        m1_done_d = 1'b1;
        m1_err_d  = end_err;
        if (!pwrite_q) m1_rdata_d = end_rdata;
      end else begin
        m0_done_d = 1'b1;
        m0_err_d  = end_err;
        if (!pwrite_q) m0_rdata_d = end_rdata;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_done_q  <= m0_done_d;
      m1_done_q  <= m1_done_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign M0_RDATA = m0_rdata_q;
  assign M1_RDATA = m1_rdata_q;
  assign M0_DONE  = m0_done_q;
  assign M1_DONE  = m1_done_q;
  assign M0_ERR   = m0_err_q;
  assign M1_ERR   = m1_err_q;

endmodule

// File: tb/tb_apb_lsram_arbiter.sv
// Bench for apb_lsram_arbiter: directed vector table, arbitration/reset sequences, and
// randomized traffic against a transaction-level model of the two requesters and the SRAM.
module tb_apb_lsram_arbiter;

  localparam int TMO = 16;

  logic        PCLK, PRESET;
  logic        M0_REQ, M0_WRITE, M1_REQ, M1_WRITE;
  logic [19:0] M0_ADDR, M1_ADDR;
  logic [31:0] M0_WDATA, M1_WDATA, PRDATA;
  logic        PREADY, PSLVERR;

  logic [31:0] M0_RDATA, M1_RDATA, PWDATA;
  logic        M0_DONE, M1_DONE, M0_ERR, M1_ERR, PSEL, PENABLE, PWRITE;
  logic [19:0] PADDR;

  logic [31:0] f_M0_RDATA, f_M1_RDATA, f_PWDATA;
  logic        f_M0_DONE, f_M1_DONE, f_M0_ERR, f_M1_ERR, f_PSEL, f_PENABLE, f_PWRITE;
  logic [19:0] f_PADDR;

  int n_cmp = 0;
  int n_err = 0;

  apb_lsram_arbiter #(.APB_DWIDTH(32), .ARB_MODE(1), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .M0_REQ(M0_REQ), .M0_WRITE(M0_WRITE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M0_RDATA(M0_RDATA), .M0_DONE(M0_DONE), .M0_ERR(M0_ERR),
    .M1_REQ(M1_REQ), .M1_WRITE(M1_WRITE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
    .M1_RDATA(M1_RDATA), .M1_DONE(M1_DONE), .M1_ERR(M1_ERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Fixed-priority instance sharing all inputs; only its grant order is examined.
  apb_lsram_arbiter #(.APB_DWIDTH(32), .ARB_MODE(0), .TIMEOUT(TMO)) dut_fp (
    .PCLK(PCLK), .PRESET(PRESET),
    .M0_REQ(M0_REQ), .M0_WRITE(M0_WRITE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M0_RDATA(f_M0_RDATA), .M0_DONE(f_M0_DONE), .M0_ERR(f_M0_ERR),
    .M1_REQ(M1_REQ), .M1_WRITE(M1_WRITE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
    .M1_RDATA(f_M1_RDATA), .M1_DONE(f_M1_DONE), .M1_ERR(f_M1_ERR),
    .PSEL(f_PSEL), .PENABLE(f_PENABLE), .PWRITE(f_PWRITE), .PADDR(f_PADDR), .PWDATA(f_PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic pulse_reset();
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
  endtask

  // One complete transfer for requester m; the slave inserts 'waits' PREADY=0 ACCESS cycles.
  task automatic do_xfer(input int m, input logic wr, input logic [19:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits,
                         input logic slverr, input logic exp_err,
                         input logic [31:0] exp_rd0, input logic [31:0] exp_rd1,
                         input string tag);
    int acc;
    int en_cnt;
    acc = (waits >= TMO) ? TMO : waits + 1;
    if (m == 0) begin
      M0_REQ = 1'b1; M0_WRITE = wr; M0_ADDR = addr; M0_WDATA = wd;
    end else begin
      M1_REQ = 1'b1; M1_WRITE = wr; M1_ADDR = addr; M1_WDATA = wd;
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
    tick();
    check({tag, "_setup_psel"}, 32'(PSEL), 32'd1);
    check({tag, "_setup_penable"}, 32'(PENABLE), 32'd0);
    check({tag, "_paddr"}, 32'(PADDR), 32'(addr));
    check({tag, "_pwrite"}, 32'(PWRITE), 32'(wr));
    if (wr) check({tag, "_pwdata"}, PWDATA, wd);
    en_cnt = 0;
    for (int i = 0; i < acc; i++) begin
      tick();
      if (PSEL && PENABLE) en_cnt++;
      PREADY  = (i == waits);
      PSLVERR = (i == waits) ? slverr : 1'($urandom_range(0, 1));
      PRDATA  = (i == waits) ? rd : $urandom;
    end
    tick();
    check({tag, "_access_cycles"}, 32'(en_cnt), 32'(acc));
    check({tag, "_done_win"}, 32'(m == 0 ? M0_DONE : M1_DONE), 32'd1);
    check({tag, "_done_other"}, 32'(m == 0 ? M1_DONE : M0_DONE), 32'd0);
    check({tag, "_err"}, 32'(m == 0 ? M0_ERR : M1_ERR), 32'(exp_err));
    check({tag, "_done_psel"}, 32'({PSEL, PENABLE}), 32'd0);
    check({tag, "_m0_rdata"}, M0_RDATA, exp_rd0);
    check({tag, "_m1_rdata"}, M1_RDATA, exp_rd1);
    PREADY = 1'b0; PSLVERR = 1'b0;
    if (m == 0) M0_REQ = 1'b0;
    else        M1_REQ = 1'b0;
    tick();
    check({tag, "_idle_done"}, 32'({M0_DONE, M1_DONE}), 32'd0);
    check({tag, "_idle_psel"}, 32'(PSEL), 32'd0);
  endtask

  typedef struct {
    int          m;
    logic        wr;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    logic        exp_err;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } vec_t;

  vec_t vecs [10];

  // Random-phase model: pending requests, shared SRAM image, expected held read data.
  logic        pend [2];
  logic        p_wr [2];
  logic [19:0] p_addr [2];
  logic [31:0] p_wd [2];
  logic [31:0] exp_rd [2];
  logic [31:0] mem [16];
  int          last;

  initial begin
    logic [3:0]  rr_seq, fp_seq;
    int          rr_cnt, fp_cnt;
    int          win, waits;
    logic        slverr, timed_out, err;
    logic [3:0]  idx;
    logic [31:0] prd;

    vecs[0] = '{0, 1'b1, 20'h00010, 32'hA5A5A5A5, 32'h0,        0,  1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1] = '{1, 1'b0, 20'h00010, 32'h0,        32'hA5A5A5A5, 0,  1'b0, 1'b0, 32'h0,        32'hA5A5A5A5};
    vecs[2] = '{0, 1'b0, 20'h00024, 32'h0,        32'h12345678, 3,  1'b0, 1'b0, 32'h12345678, 32'hA5A5A5A5};
    vecs[3] = '{1, 1'b1, 20'h00030, 32'hDEADBEEF, 32'h0,        0,  1'b1, 1'b1, 32'h12345678, 32'hA5A5A5A5};
    vecs[4] = '{1, 1'b0, 20'h00030, 32'h0,        32'h0BADF00D, 0,  1'b0, 1'b0, 32'h12345678, 32'h0BADF00D};
    vecs[5] = '{0, 1'b0, 20'h00044, 32'h0,        32'hCAFEF00D, 16, 1'b0, 1'b1, 32'h0,        32'h0BADF00D};
    vecs[6] = '{1, 1'b1, 20'hFFFFF, 32'h00000005, 32'h0,        1,  1'b0, 1'b0, 32'h0,        32'h0BADF00D};
    vecs[7] = '{0, 1'b0, 20'h00008, 32'h0,        32'hFFFFFFFF, 0,  1'b1, 1'b1, 32'hFFFFFFFF, 32'h0BADF00D};
    vecs[8] = '{1, 1'b1, 20'h00004, 32'h11112222, 32'h0,        15, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0BADF00D};
    vecs[9] = '{1, 1'b0, 20'h00004, 32'h0,        32'h55AA55AA, 40, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0};

    PRESET = 1'b1;
    M0_REQ = 1'b0; M0_WRITE = 1'b0; M0_ADDR = '0; M0_WDATA = '0;
    M1_REQ = 1'b0; M1_WRITE = 1'b0; M1_ADDR = '0; M1_WDATA = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick();
    tick();
    check("reset_apb", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
    check("reset_paddr", 32'(PADDR), 32'd0);
    check("reset_pwdata", PWDATA, 32'd0);
    check("reset_done_err", 32'({M0_DONE, M1_DONE, M0_ERR, M1_ERR}), 32'd0);
    check("reset_rdata", M0_RDATA | M1_RDATA, 32'd0);
    PRESET = 1'b0;

    foreach (vecs[k])
      do_xfer(vecs[k].m, vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].prdata,
              vecs[k].waits, vecs[k].slverr, vecs[k].exp_err, vecs[k].exp_rd0,
              vecs[k].exp_rd1, $sformatf("vec%0d", k));

    // Both requesters held for four back-to-back transfers on both instances.
    pulse_reset();
    M0_REQ = 1'b1; M0_WRITE = 1'b0; M0_ADDR = 20'h00100;
    M1_REQ = 1'b1; M1_WRITE = 1'b0; M1_ADDR = 20'h00200;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0000BEEF;
    rr_seq = '0; fp_seq = '0; rr_cnt = 0; fp_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (M0_DONE || M1_DONE) begin rr_seq = {rr_seq[2:0], M1_DONE}; rr_cnt++; end
      if (f_M0_DONE || f_M1_DONE) begin fp_seq = {fp_seq[2:0], f_M1_DONE}; fp_cnt++; end
    end
    M0_REQ = 1'b0; M1_REQ = 1'b0; PREADY = 1'b0;
    check("rr_grant_count", 32'(rr_cnt), 32'd4);
    check("rr_grant_order", 32'(rr_seq), 32'b0101);
    check("fp_grant_count", 32'(fp_cnt), 32'd4);
    check("fp_grant_order", 32'(fp_seq), 32'b0000);
    tick();

    // Reset asserted mid-ACCESS, then contention right after release.
    M1_REQ = 1'b1; M1_WRITE = 1'b0; M1_ADDR = 20'h00050;
    tick();
    tick();
    tick();
    check("pre_reset_penable", 32'({PSEL, PENABLE}), 32'b11);
    PRESET = 1'b1;
    #1;
    check("async_reset_apb", 32'({PSEL, PENABLE}), 32'd0);
    M0_REQ = 1'b1; M0_WRITE = 1'b0; M0_ADDR = 20'h00060;
    tick();
    check("reset_no_done_a", 32'({M0_DONE, M1_DONE}), 32'd0);
    tick();
    check("reset_no_done_b", 32'({M0_DONE, M1_DONE}), 32'd0);
    check("reset_clears_rdata", M0_RDATA | M1_RDATA, 32'd0);
    PRESET = 1'b0;
    PREADY = 1'b1; PRDATA = 32'h600D600D;
    tick();
    check("post_reset_grant_addr", 32'(PADDR), 32'h00060);
    tick();
    tick();
    check("post_reset_m0_done", 32'({M0_DONE, M1_DONE}), 32'b10);
    check("post_reset_m0_rdata", M0_RDATA, 32'h600D600D);
    M0_REQ = 1'b0; M1_REQ = 1'b0; PREADY = 1'b0;
    tick();

    // Randomized traffic against the transaction-level model.
    pulse_reset();
    last = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int it = 0; it < 80; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 9) < 6) begin
          pend[m]   = 1'b1;
          p_wr[m]   = 1'($urandom_range(0, 1));
          p_addr[m] = 20'($urandom_range(0, 15) * 4);
          p_wd[m]   = $urandom;
        end
      end
      M0_REQ = pend[0]; M0_WRITE = p_wr[0]; M0_ADDR = p_addr[0]; M0_WDATA = p_wd[0];
      M1_REQ = pend[1]; M1_WRITE = p_wr[1]; M1_ADDR = p_addr[1]; M1_WDATA = p_wd[1];
      if (!pend[0] && !pend[1]) begin
        tick();
        check("rnd_idle_psel", 32'(PSEL), 32'd0);
        continue;
      end
      if (pend[0] && pend[1]) win = (last == 0) ? 1 : 0;
      else                    win = pend[1] ? 1 : 0;
      waits     = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      slverr    = ($urandom_range(0, 7) == 0);
      timed_out = (waits >= TMO);
      err       = timed_out || slverr;
      idx       = p_addr[win][5:2];
      prd       = mem[idx];
      if (!p_wr[win]) exp_rd[win] = timed_out ? 32'h0 : prd;
      if (p_wr[win] && !err) mem[idx] = p_wd[win];
      do_xfer(win, p_wr[win], p_addr[win], p_wd[win], prd, waits, slverr, err,
              exp_rd[0], exp_rd[1], "rnd");
      last      = win;
      pend[win] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
